// File: rtl/sigmoid_pkg.sv
// Shared types and Q8.8 constants for the sigmoid activation blocks.
// Imported by the core, the request interface users and the arbiter.
package sigmoid_pkg;

   typedef logic [15:0] q8_8_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   localparam q8_8_t Q_ONE  = 16'h0100;
   localparam q8_8_t Q_HALF = 16'h0080;

endpackage

// File: rtl/sigmoid_req_arbiter_if.sv
// Request/response bundle between the activation requesters and the
// shared sigmoid arbiter; master is the requester side.
interface sigmoid_req_arbiter_if #(
   parameter int NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_x;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [15:0]           rsp_y;
   logic                  busy;

   modport master (
      output req_valid, req_x, rsp_ready,
      input  req_ready, rsp_valid, rsp_y, busy
   );

   modport slave (
      input  req_valid, req_x, rsp_ready,
      output req_ready, rsp_valid, rsp_y, busy
   );

endinterface

// File: rtl/sigmoid_core.sv
// Combinational piecewise sigmoid on Q8.8: each integer step of |x|
// halves the distance to the rail, with a linear term inside the step.
module sigmoid_core
   import sigmoid_pkg::*;
(
   input  q8_8_t x,
   output q8_8_t y
);

   q8_8_t      a;
   q8_8_t      f;
   q8_8_t      d;
   q8_8_t      h;
   logic [7:0] n;
   logic [7:0] frac;

   always_comb begin
      // 0x8000 negates to itself, which lands in the saturated range
      a    = x[15] ? (16'd0 - x) : x;
      n    = a[15:8];
      frac = a[7:0];
      f    = {8'd0, frac >> 2};
      d    = Q_HALF - f;
      h    = (n >= 8'd8) ? 16'd0 : (d >> n[2:0]);
      y    = x[15] ? h : (Q_ONE - h);
   end

endmodule

// File: rtl/sigmoid_req_arbiter.sv
// Round-robin arbiter sharing one sigmoid_core between NUM_REQ
// requesters, one operand in flight at a time.
module sigmoid_req_arbiter
   import sigmoid_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sigmoid_req_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_REQ);
   typedef logic [IW-1:0] idx_t;

   state_t             state;
   idx_t               rr_ptr;
   idx_t               gnt_q;
   idx_t               win;
   logic               found;
   int                 j;
   q8_8_t              x_q;
   q8_8_t              y_q;
   q8_8_t              core_y;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic               busy_q;

   // First valid requester at or above rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && bus.req_valid[j]) begin
            found = 1'b1;
            win   = idx_t'(j);
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state == IDLE && found) bus.req_ready[win] = 1'b1;
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = y_q;
   assign bus.busy      = busy_q;

   sigmoid_core u_core (
      .x (x_q),
      .y (core_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         gnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  x_q    <= bus.req_x[16*int'(win) +: 16];
                  gnt_q  <= win;
                  busy_q <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               y_q                <= core_y;
               rsp_valid_q        <= '0;
               rsp_valid_q[gnt_q] <= 1'b1;
               state              <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[gnt_q]) begin
                  rr_ptr      <= (gnt_q == idx_t'(NUM_REQ-1)) ?
                                 '0 : gnt_q + 1'b1;
                  rsp_valid_q <= '0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sigmoid_req_arbiter.md
# sigmoid_req_arbiter

Shares one Q8.8 sigmoid approximation datapath between `NUM_REQ` independent requesters. Each requester issues a 16-bit signed Q8.8 operand over a valid/ready handshake and gets a 16-bit unsigned Q8.8 result back on its own response channel. Grants are round-robin, and only one operand is in flight at a time. The block sits between the accelerator's activation-request ports and the shared `sigmoid_core`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: active-low asynchronous reset. One clock; reset is asynchronous and active-low.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept. At most one bit high per cycle.
- `req_x`, in, `NUM_REQ*16`: operands. Requester i uses `req_x[16i+15:16i]`, signed Q8.8.
- `rsp_valid`, out, `NUM_REQ`: per-requester result valid.
- `rsp_ready`, in, `NUM_REQ`: per-requester result accept.
- `rsp_y`, out, 16: result, unsigned Q8.8, range 0x0000..0x0100. Shared by all requesters; qualified by `rsp_valid`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - Winner: the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - Drive `req_ready[winner]`=1 combinationally.
  - On the handshake: latch `req_x[winner]` into `x_q`, latch winner into `gnt_q`, go to CALC.
  - If no `req_valid` is high: stay in IDLE, all `req_ready`=0.
- **CALC**
  - Present `x_q` to `sigmoid_core`.
  - Register its output into `y_q`, go to RESP.
- **RESP**
  - Drive `rsp_valid[gnt_q]`=1 and `rsp_y`=`y_q`.
  - On `rsp_ready[gnt_q]`: set `rr_ptr` = (`gnt_q`+1) mod `NUM_REQ`, go to IDLE.
  - Otherwise hold, with `y_q` stable.
- `req_ready` is 0 in CALC and RESP. `rsp_ready` of non-granted requesters is ignored.
- Arithmetic (`sigmoid_core`, combinational):
  - a = |x|, with 0x8000 mapping to 0x8000.
  - n = a[15:8], f = a[7:0]>>2.
  - h = (128 − f) >> n. Any n ≥ 8 gives h=0.
  - y = (x[15]==1) ? h : 0x0100 − h.
  - All intermediates are 16 bits and never wrap, because 0 ≤ 128 − f ≤ 128.
- Reset values: state=IDLE, `rr_ptr`=0, `gnt_q`=0, `x_q`=0, `y_q`=0. Therefore `req_ready`=0 unless a `req_valid` is high in IDLE, `rsp_valid`=0, `rsp_y`=0, `busy`=0.

## Timing
- Accept handshake in cycle t → `rsp_valid` high in cycle t+2. Minimum issue interval is 3 cycles when `rsp_ready` is held high.
- `req_ready` depends combinationally on `req_valid` and state only. No other input-to-output combinational path exists.
- A requester may drop `req_valid` without a handshake; nothing is latched.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins, with wrap. With all valid and `rsp_ready` high, grants go 0,1,2,3,0,…
- `rsp_ready` arriving before `rsp_valid` has no effect.
- Asserting `rst_n` low in CALC or RESP aborts the transaction: no response is produced, and outputs return to reset values immediately (asynchronous).

## Structure
- Package `sigmoid_pkg`:
  - `q8_8_t` (16-bit),
  - FSM state enum,
  - constants `Q_ONE`=0x0100 and `Q_HALF`=0x0080.
- Sub-module `sigmoid_core`: purely combinational, ports `x` (in, 16) and `y` (out, 16). It is reused by other activation blocks.
- Round-robin pick lives inline in the arbiter.

## Test plan
- Single requester 0, x=0x0000 → after 2 cycles `rsp_valid[0]`=1, `rsp_y`=0x0080.
- Value sweep on requester 1:
  - 0x0100 → 0x00C0
  - 0xFF00 → 0x0040
  - 0x0200 → 0x00E0
  - 0x0080 → 0x00A0
  - 0xFF80 → 0x0060
  - 0x7FFF → 0x0100
  - 0x8000 → 0x0000
- All four requesters valid continuously with `rsp_ready` high → grant order 0,1,2,3,0. Each `rsp_valid` 2 cycles after its accept; an issue every 3 cycles.
- `rsp_ready[2]` held low for 5 cycles in RESP → `rsp_y` stable, all `req_ready`=0, `busy`=1. After release → IDLE next cycle and `rr_ptr`=3.
- `rst_n` pulsed low during CALC → `rsp_valid`=0 and `busy`=0 immediately. After release, the next grant goes to requester 0.
- `rsp_ready` high on a non-granted requester during RESP → ignored; the FSM stays in RESP.
